// File: rtl/decoder_4x16.sv
// Registered 4-to-16 one-hot line decoder with enable.
// A 2x4 on {c1,c} gates four 2x4 decoders on {d1,d}.
module decoder_4x16 #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic c1,
  input  logic c,
  input  logic d1,
  input  logic d,
  output logic D0,
  output logic D1,
  output logic D2,
  output logic D3,
  output logic D4,
  output logic D5,
  output logic D6,
  output logic D7,
  output logic D8,
  output logic D9,
  output logic D10,
  output logic D11,
  output logic D12,
  output logic D13,
  output logic D14,
  output logic D15
);

  function automatic logic [3:0] dec2x4(
    input logic       e,
    input logic [1:0] s
  );
    logic [3:0] o;
    o = 4'b0000;
    if (e) begin
      unique case (s)
        2'd0: o = 4'b0001;
        2'd1: o = 4'b0010;
        2'd2: o = 4'b0100;
        2'd3: o = 4'b1000;
        default: o = 4'b0000;
      endcase
    end
    return o;
  endfunction

  logic [3:0]  g;
  logic [15:0] f;
  logic [15:0] q;

  assign g = dec2x4(en, {c1, c});

  for (genvar k = 0; k < 4; k++) begin : g_leaf
    assign f[4*k +: 4] = dec2x4(g[k], {d1, d});
  end

  if (OUT_REG) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else     q <= f;
    end
  end else begin : g_comb
    assign q = f;
  end

  assign {D15, D14, D13, D12, D11, D10, D9, D8,
          D7,  D6,  D5,  D4,  D3,  D2,  D1, D0} = q;

endmodule

// File: tb/tb_decoder_4x16.sv
// Bench for decoder_4x16: scoreboarded registered build
// plus direct checks of the combinational build.
module tb_decoder_4x16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic c1 = 1'b0, c = 1'b0, d1 = 1'b0, d = 1'b0;
  logic [15:0] dout;

  logic en0 = 1'b0;
  logic [3:0] s0 = 4'd0;
  logic [15:0] cout;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  decoder_4x16 #(.OUT_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en),
    .c1(c1), .c(c), .d1(d1), .d(d),
    .D0(dout[0]),   .D1(dout[1]),   .D2(dout[2]),   .D3(dout[3]),
    .D4(dout[4]),   .D5(dout[5]),   .D6(dout[6]),   .D7(dout[7]),
    .D8(dout[8]),   .D9(dout[9]),   .D10(dout[10]), .D11(dout[11]),
    .D12(dout[12]), .D13(dout[13]), .D14(dout[14]), .D15(dout[15])
  );

  decoder_4x16 #(.OUT_REG(1'b0)) dut_c (
    .clk(clk), .rst(rst), .en(en0),
    .c1(s0[3]), .c(s0[2]), .d1(s0[1]), .d(s0[0]),
    .D0(cout[0]),   .D1(cout[1]),   .D2(cout[2]),   .D3(cout[3]),
    .D4(cout[4]),   .D5(cout[5]),   .D6(cout[6]),   .D7(cout[7]),
    .D8(cout[8]),   .D9(cout[9]),   .D10(cout[10]), .D11(cout[11]),
    .D12(cout[12]), .D13(cout[13]), .D14(cout[14]), .D15(cout[15])
  );

  function automatic logic [15:0] model(
    input logic r, input logic e, input int s
  );
    logic [15:0] v;
    v = 16'd0;
    if (!r && e) v = 16'(1 << s);
    return v;
  endfunction

  task automatic check(
    input string name, input logic [15:0] act, input logic [15:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step(
    input logic r, input logic e, input logic [3:0] s
  );
    @(negedge clk);
    rst = r;
    en = e;
    {c1, c, d1, d} = s;
    exp_q.push_back(model(r, e, int'(s)));
  endtask

  // Monitor: compare after each edge, then confirm hold before next edge
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("edge", dout, e);
        checks++;
        if ($countones(dout) > 1) begin
          errors++;
          $display("FAIL onehot: got %h expected at most one bit", dout);
        end
        #6;
        check("hold", dout, e);
      end
    end
  end

  initial begin
    step(1'b1, 1'b1, 4'd15);
    step(1'b1, 1'b1, 4'd15);
    step(1'b0, 1'b1, 4'd15);
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd9);
    step(1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b1, 4'd12);
    step(1'b0, 1'b1, 4'd3);
    step(1'b0, 1'b1, 4'd6);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i));
    step(1'b0, 1'b1, 4'd10);
    step(1'b0, 1'b0, 4'd10);
    step(1'b0, 1'b1, 4'd10);
    step(1'b1, 1'b1, 4'd10);
    step(1'b0, 1'b1, 4'd10);
    for (int i = 0; i < 200; i++)
      step(($urandom % 16) == 0, ($urandom % 4) != 0, 4'($urandom));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    s0 = 4'd7; en0 = 1'b1;
    #1 check("comb_s7", cout, 16'h0080);
    en0 = 1'b0;
    #1 check("comb_off", cout, 16'h0000);
    for (int i = 0; i < 32; i++) begin
      s0 = 4'($urandom);
      en0 = 1'($urandom);
      #1 check("comb_rand", cout, model(1'b0, en0, int'(s0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decoder_4x16.md
Name: decoder_4x16

Overview:
- Registered 4-to-16 line decoder with enable. It produces one-hot, active-high outputs.
- Built as a two-level tree of 2-to-4 decoders:
  - a first-level 2x4 decoder on (c1, c) selects one of four second-level 2x4 decoders;
  - each second-level decoder decodes (d1, d).
- Used as a generic address/select decoder. It sits downstream of any 4-bit select source.

Parameters:
- OUT_REG, 1, 1 = outputs registered on clk (1-cycle latency); 0 = outputs purely combinational (clk/rst unused).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous active-high reset
- en   input  1  decoder enable, active high
- c1   input  1  select bit 3 (MSB)
- c    input  1  select bit 2
- d1   input  1  select bit 1
- d    input  1  select bit 0 (LSB)
- D0..D15  output  1 each  one-hot decoded lines; Dn high when select index = n and en = 1

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst).
- Select index: S = {c1, c, d1, d} = 8*c1 + 4*c + 2*d1 + d, range 0..15.
- Decode function F(S, en):
  - en=1: exactly one line high, D[S]=1, all others 0.
  - en=0: all 16 lines 0.
- Tree structure:
  - first-level 2x4 on {c1,c}, gated by en, produces group enables g0..g3;
  - second-level decoder k decodes {d1,d} into D[4k+0..4k+3], gated by gk.
  - Results must equal the flat function F.
- OUT_REG=1:
  - at each rising clk, if rst=1 then all D0..D15 <= 0;
  - else D0..D15 <= F(S, en) sampled at that edge;
  - latency exactly 1 cycle; outputs hold between edges regardless of input changes.
- OUT_REG=0:
  - D = F(S, en) combinationally; rst and clk have no effect.
- Reset value: all outputs 0 (OUT_REG=1).
- Reset priority: rst dominates en and select on the same edge.
- Reset mid-operation: the asserted line clears at the next edge; decoding resumes on the first edge with rst=0.
- One-hot invariant: at most one output high at any time; never more than one, including across reset release and enable toggling.
- Select changes while en=1: the old line deasserts and the new line asserts on the same edge; no intermediate all-zero or two-hot cycle.
- en falling: all outputs 0 after the next edge. en rising: D[S] high after the next edge.
- No X propagation: inputs are assumed 0/1. The output register holds only 0/1 after reset.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, c1=c=d1=d=1 -> all D0..D15 = 0. Release rst -> D15=1 after one edge.
- Disable: en=0, all select bits 0 -> all outputs 0. Then en=0 with S=9 -> still all 0.
- Directed codes with en=1 -> required line after one edge, all others 0:
  - c=1, c1=0, d=1, d1=0 -> D5=1;
  - c=1, c1=1, d=0, d1=0 -> D12=1;
  - c=0, c1=0, d=1, d1=1 -> D3=1;
  - c=1, c1=0, d=0, d1=1 -> D6=1.
- Exhaustive sweep: en=1, S=0..15, one per cycle -> D[S]=1 exactly one cycle after S is applied. Popcount of outputs = 1 every cycle.
- Enable/reset interaction: hold S=10, toggle en 1,0,1, then assert rst one cycle -> D10 follows en with 1-cycle delay and clears on the rst edge.
- OUT_REG=0 build: apply S=7, en=1 with no clock -> D7=1 immediately. en=0 -> all 0 immediately.
